// File: rtl/waves_pkg.sv
// waves_pkg: shared waveform enum, ASCII command codes and UART receiver states.
package waves_pkg;
   typedef enum logic [2:0] {SQUARE = 3'd0, TRIANGLE = 3'd1, SAW = 3'd2, SINE = 3'd3} wave_t;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
   localparam logic [7:0] CMD_SQUARE    = 8'h51;
   localparam logic [7:0] CMD_TRI       = 8'h54;
   localparam logic [7:0] CMD_SAW       = 8'h53;
   localparam logic [7:0] CMD_SINE      = 8'h49;
   localparam logic [7:0] CMD_NOISE_ON  = 8'h4E;
   localparam logic [7:0] CMD_NOISE_OFF = 8'h46;
endpackage

// File: rtl/uart_cmd_decoder_if.sv
// uart_cmd_decoder_if: UART line in, decoded wave controls and status pulses out.
interface uart_cmd_decoder_if;
   logic       rx;
   logic [2:0] wave_select;
   logic       white_noise_en;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       cmd_unknown;
   logic       frame_err;
   modport master(output rx, input wave_select, white_noise_en, rx_data, rx_valid, cmd_unknown, frame_err);
   modport slave(input rx, output wave_select, white_noise_en, rx_data, rx_valid, cmd_unknown, frame_err);
endinterface

// File: rtl/uart_cmd_decoder_rx_core.sv
// uart_rx_core: 8N1 receiver with 2-FF synchronizer; valid_o/ferr_o strobe during the stop-bit sample.
module uart_rx_core
   import waves_pkg::*;
#(
   parameter int CLK_FREQ = 25_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       valid_o,
   output logic       ferr_o
);
   localparam int DIV  = CLK_FREQ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);
   localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   logic          s1_q, s2_q;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    sh_q, sh_d;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
      end else begin
         s1_q    <= rx_i;
         s2_q    <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
      end
   end
   // Counter is cleared on every transition so it never wraps mid-bit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      sh_d    = sh_q;
      valid_o = 1'b0;
      ferr_o  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!s2_q) state_d = START;
         end
         START: if (cnt_q == HALF_M1) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = s2_q ? IDLE : DATA;
         end
         DATA: if (cnt_q == DIV_M1) begin
            cnt_d = '0;
            sh_d  = {s2_q, sh_q[7:1]};
            idx_d = idx_q + 1'b1;
            if (idx_q == 3'd7) state_d = STOP;
         end
         STOP: if (cnt_q == DIV_M1) begin
            cnt_d   = '0;
            valid_o = s2_q;
            ferr_o  = !s2_q;
            state_d = s2_q ? IDLE : BREAK;
         end
         BREAK: begin
            cnt_d = '0;
            if (s2_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   assign byte_o = sh_q;
endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: UART command receiver driving registered wave/noise controls.
// Define UART_CASE_FOLD_EN to accept lowercase command letters.
module uart_cmd_decoder
   import waves_pkg::*;
#(
   parameter int CLK_FREQ = 25_000_000,
   parameter int BAUD     = 9600
) (
   input logic                clk,
   input logic                rst_n,
   uart_cmd_decoder_if.slave  bus
);
   logic [7:0] rx_byte, b;
   logic       valid, ferr, known;
   wave_t      wave_q, wave_d;
   logic       noise_q, noise_d;
   logic [7:0] data_q;
   logic       valid_q, unk_q, ferr_q;
   uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_core (
      .clk(clk), .rst_n(rst_n), .rx_i(bus.rx),
      .byte_o(rx_byte), .valid_o(valid), .ferr_o(ferr)
   );
   always_comb begin
`ifdef UART_CASE_FOLD_EN
      b = (rx_byte inside {[8'h61:8'h7A]}) ? (rx_byte & 8'hDF) : rx_byte;
`else
      b = rx_byte;
`endif
      known   = b inside {CMD_SQUARE, CMD_TRI, CMD_SAW, CMD_SINE, CMD_NOISE_ON, CMD_NOISE_OFF};
      wave_d  = !valid ? wave_q : b == CMD_SQUARE ? SQUARE : b == CMD_TRI ? TRIANGLE :
                b == CMD_SAW ? SAW : b == CMD_SINE ? SINE : wave_q;
      noise_d = !valid ? noise_q : b == CMD_NOISE_ON ? 1'b1 : b == CMD_NOISE_OFF ? 1'b0 : noise_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wave_q  <= SQUARE;
         noise_q <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         unk_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         wave_q  <= wave_d;
         noise_q <= noise_d;
         data_q  <= valid ? rx_byte : data_q;
         valid_q <= valid;
         unk_q   <= valid && !known;
         ferr_q  <= ferr;
      end
   end
   assign bus.wave_select    = wave_q;
   assign bus.white_noise_en = noise_q;
   assign bus.rx_data        = data_q;
   assign bus.rx_valid       = valid_q;
   assign bus.cmd_unknown    = unk_q;
   assign bus.frame_err      = ferr_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed UART frames with expected pulse counts and control values.
module tb_uart_cmd_decoder;
   import waves_pkg::*;
   localparam int CLK_FREQ = 3_200_000;
   localparam int BAUD     = 100_000;
   localparam int DIV      = CLK_FREQ / BAUD;
   localparam int HALF     = DIV / 2;
   typedef struct {
      logic [7:0] d;
      logic       stop;
      int         v, u, f;
      logic [2:0] w;
      logic       n;
      logic [7:0] ed;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0, n_err = 0, n_chk = 0;
   int   n_v = 0, n_u = 0, n_f = 0, n_bad = 0;
   logic pv = 1'b0, pu = 1'b0, pf = 1'b0;
   vec_t vt[13];
   uart_cmd_decoder_if u_if();
   uart_cmd_decoder #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));
   always #10 clk = ~clk;
   // Pulse monitor: counts pulses and flags any pulse wider than one cycle or a stray cmd_unknown.
   always @(negedge clk) begin
      if (u_if.rx_valid) n_v++;
      if (u_if.cmd_unknown) n_u++;
      if (u_if.frame_err) n_f++;
      if ((u_if.rx_valid && pv) || (u_if.cmd_unknown && pu) || (u_if.frame_err && pf) ||
          (u_if.cmd_unknown && !u_if.rx_valid)) n_bad++;
      pv = u_if.rx_valid;
      pu = u_if.cmd_unknown;
      pf = u_if.frame_err;
   end
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   task automatic ticks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask
   task automatic send(input logic [7:0] b, input logic stop);
      u_if.rx = 1'b0;
      ticks(DIV);
      for (int i = 0; i < 8; i++) begin
         u_if.rx = b[i];
         ticks(DIV);
      end
      u_if.rx = stop;
      ticks(DIV);
   endtask
   task automatic clr();
      n_v = 0;
      n_u = 0;
      n_f = 0;
   endtask
   task automatic chk_all(input string tag, input int v, input int u, input int f,
                          input logic [2:0] w, input logic n, input logic [7:0] d);
      chk({tag, ".valid"}, v, n_v);
      chk({tag, ".unknown"}, n_u, u);
      chk({tag, ".frame_err"}, n_f, f);
      chk({tag, ".wave"}, 32'(u_if.wave_select), 32'(w));
      chk({tag, ".noise"}, 32'(u_if.white_noise_en), 32'(n));
      chk({tag, ".rx_data"}, 32'(u_if.rx_data), 32'(d));
   endtask
   initial begin
      vt = '{
         '{8'h54, 1'b1, 1, 0, 0, 3'd1, 1'b0, 8'h54},
         '{8'h53, 1'b1, 1, 0, 0, 3'd2, 1'b0, 8'h53},
         '{8'h4E, 1'b1, 1, 0, 0, 3'd2, 1'b1, 8'h4E},
         '{8'h46, 1'b1, 1, 0, 0, 3'd2, 1'b0, 8'h46},
         '{8'h41, 1'b1, 1, 1, 0, 3'd2, 1'b0, 8'h41},
         '{8'h54, 1'b0, 0, 0, 1, 3'd2, 1'b0, 8'h41},
         '{8'h49, 1'b1, 1, 0, 0, 3'd3, 1'b0, 8'h49},
         '{8'h53, 1'b1, 1, 0, 0, 3'd2, 1'b0, 8'h53},
         '{8'h51, 1'b1, 1, 0, 0, 3'd0, 1'b0, 8'h51},
         '{8'h4E, 1'b1, 1, 0, 0, 3'd0, 1'b1, 8'h4E},
         '{8'h00, 1'b1, 1, 1, 0, 3'd0, 1'b1, 8'h00},
         '{8'hFF, 1'b1, 1, 1, 0, 3'd0, 1'b1, 8'hFF},
         '{8'h49, 1'b1, 1, 0, 0, 3'd3, 1'b1, 8'h49}
      };
      u_if.rx = 1'b1;
      ticks(4);
      n_vec++;
      chk_all("reset", 0, 0, 0, 3'd0, 1'b0, 8'h00);
      chk("reset.state", 32'(u_dut.u_core.state_q), 32'(IDLE));
      rst_n = 1'b1;
      ticks(4);
      foreach (vt[k]) begin
         clr();
         send(vt[k].d, vt[k].stop);
         if (!vt[k].stop) ticks(3 * DIV);
         u_if.rx = 1'b1;
         ticks(2 * DIV);
         n_vec++;
         chk_all($sformatf("vec%0d", k), vt[k].v, vt[k].u, vt[k].f, vt[k].w, vt[k].n, vt[k].ed);
      end
      clr();
      send(8'h54, 1'b1);
      send(8'h53, 1'b1);
      ticks(2 * DIV);
      n_vec++;
      chk_all("b2b", 2, 0, 0, 3'd2, 1'b1, 8'h53);
      clr();
      u_if.rx = 1'b0;
      #200;
      u_if.rx = 1'b1;
      ticks(HALF + 5);
      n_vec++;
      chk("glitch.state", 32'(u_dut.u_core.state_q), 32'(IDLE));
      ticks(2 * DIV);
      chk_all("glitch", 0, 0, 0, 3'd2, 1'b1, 8'h53);
      clr();
      u_if.rx = 1'b0;
      ticks(DIV);
      u_if.rx = 1'b1;
      ticks(DIV);
      u_if.rx = 1'b1;
      ticks(DIV + 3);
      rst_n = 1'b0;
      ticks(2);
      n_vec++;
      chk_all("midrst", 0, 0, 0, 3'd0, 1'b0, 8'h00);
      u_if.rx = 1'b1;
      rst_n = 1'b1;
      ticks(2 * DIV);
      chk("midrst.state", 32'(u_dut.u_core.state_q), 32'(IDLE));
      clr();
      send(8'h74, 1'b1);
      ticks(2 * DIV);
      n_vec++;
`ifdef UART_CASE_FOLD_EN
      chk_all("lower_t", 1, 0, 0, 3'd1, 1'b0, 8'h74);
`else
      chk_all("lower_t", 1, 1, 0, 3'd0, 1'b0, 8'h74);
`endif
      chk("pulse_shape", n_bad, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Upstream control stage of the wave generator. Receives 8N1 UART bytes on `rx`, validates the framing and decodes single-character ASCII commands. Drives the registered `wave_select` / `white_noise_en` controls consumed by the waveform synthesis datapath that produces `uo_out`.

## Interface
Parameters:
- `CLK_FREQ`, default 25_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: UART bit rate.
- Derived: `DIV = CLK_FREQ/BAUD`, truncated (2604 at defaults); `HALF = DIV/2` (1302).

Ports:
- `clk`  in  1: single clock domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rx`  in  1: asynchronous UART line, idle high.
- `wave_select`  out  3: active waveform. 0 = square, 1 = triangle, 2 = sawtooth, 3 = sine, 4–7 unused.
- `white_noise_en`  out  1: noise overlay enable.
- `rx_data`  out  8: last correctly framed byte.
- `rx_valid`  out  1: one-cycle pulse for each correctly framed byte.
- `cmd_unknown`  out  1: one-cycle pulse when a correctly framed byte is not a command.
- `frame_err`  out  1: one-cycle pulse when the stop bit samples low.

## Operation
- `rx` passes through a 2-FF synchronizer, preset to 1 on reset. All logic below uses the synchronized value `rxs`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - **IDLE:** when `rxs`=0, clear the counter and go to START.
  - **START:** count to `HALF-1`. At that point, if `rxs`=0 go to DATA with the counter and bit index cleared. Otherwise go to IDLE; this is a glitch and is ignored silently.
  - **DATA:** count to `DIV-1`, then sample `rxs` into the shift register, LSB first. After bit index 7, go to STOP.
  - **STOP:** count to `DIV-1`, then sample.
    - `rxs`=1: latch `rx_data`, pulse `rx_valid`, decode the byte, go to IDLE.
    - `rxs`=0: pulse `frame_err`, discard the byte, go to BREAK.
  - **BREAK:** stay until `rxs`=1, then go to IDLE. A held-low line therefore never produces repeated frames.
- Command decode applies only to correctly framed bytes:
  - 0x51 'Q' → `wave_select`=0
  - 0x54 'T' → `wave_select`=1
  - 0x53 'S' → `wave_select`=2
  - 0x49 'I' → `wave_select`=3
  - 0x4E 'N' → `white_noise_en`=1
  - 0x46 'F' → `white_noise_en`=0
  - Any other byte: controls unchanged, `cmd_unknown` pulses together with `rx_valid`.
- Controls hold their value indefinitely between commands.
- Counter width is `$clog2(DIV)` bits. The counter never wraps mid-bit because it is cleared at every state transition.

## Timing
- Reset values:
  - `wave_select`=0, `white_noise_en`=0, `rx_data`=0x00.
  - All pulses 0.
  - FSM in IDLE, synchronizer flops = 1.
- Latency from the `rx` falling edge to START entry is 3 clocks: 2 synchronizer + 1 IDLE register.
- The stop-bit sample falls at about 9.5 bit times after the start edge, plus 3 clocks.
- Outputs after the stop-bit sample:
  - `rx_valid`, `cmd_unknown`, `frame_err`, `rx_data` and the updated controls all appear on the clock edge after the stop-bit sample.
  - Pulses are exactly 1 cycle wide.
- Back-to-back bytes with no idle gap are accepted: IDLE detects the next start bit on the cycle after STOP exits.
- Reset asserted mid-frame aborts at once. The partial byte is lost and no pulse is produced. After release, the receiver waits for a fresh falling edge.

## Configuration
- `UART_CASE_FOLD_EN`:
  - Defined: lowercase 'q','t','s','i','n','f' (0x71, 0x74, 0x73, 0x69, 0x6E, 0x66) decode identically to their uppercase forms.
  - Undefined: lowercase letters are unknown bytes and pulse `cmd_unknown`.

## Structure
- Shared package `waves_pkg` holds:
  - The `wave_t` enum: SQUARE=0, TRIANGLE=1, SAW=2, SINE=3.
  - ASCII command constants `CMD_SQUARE`, `CMD_TRI`, `CMD_SAW`, `CMD_SINE`, `CMD_NOISE_ON`, `CMD_NOISE_OFF`.
  - The FSM state typedef.
- One sub-module, `uart_rx_core`: synchronizer, FSM and shift register. It outputs byte/valid/frame_err.
- The top level adds the registered command decode.

## Test plan
- Reset, then send 0x54 at 9600 baud → one `rx_valid` pulse, `rx_data`=0x54, `wave_select`=1; then send 0x53 → `wave_select`=2.
- Send 0x4E, then 0x46 → `white_noise_en` goes 1 then 0; `wave_select` unchanged.
- Send 0x41 'A' → `rx_valid` and `cmd_unknown` pulse together; controls unchanged.
- Send 0x54 with the stop bit driven low, then hold `rx` low for 3 bit times → one `frame_err` pulse, no `rx_valid`, `wave_select` unchanged. After `rx` returns high, send 0x53 → `wave_select`=2.
- Drive a 200 ns low glitch on idle `rx` → no pulses, FSM back in IDLE within `HALF`+3 clocks.
- Assert `rst_n` low mid-byte during 0x53 → all outputs return to reset values. Then send 0x74 → with `UART_CASE_FOLD_EN` defined, `wave_select`=1; without it, `cmd_unknown` pulses.
